// File: rtl/sram_dp_be.sv
// Dual-read, single-write SRAM with per-byte write enables.
// A clear sequencer zeroes every word after reset before reporting Ready.
module sram_dp_be #(
    parameter int DW    = 32,
    parameter int AW    = 10,
    parameter int DEPTH = 1024
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              WE,
    input  logic [DW/8-1:0]   ByteEn,
    input  logic [AW-1:0]     WriteAddress,
    input  logic [DW-1:0]     WriteBus,
    input  logic              RE1,
    input  logic [AW-1:0]     ReadAddress1,
    input  logic              RE2,
    input  logic [AW-1:0]     ReadAddress2,
    output logic [DW-1:0]     ReadBus1,
    output logic [DW-1:0]     ReadBus2,
    output logic              RValid1,
    output logic              RValid2,
    output logic              Ready
);

    localparam int          NB      = DW / 8;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [DW-1:0]   mem_q [DEPTH];
    logic [DW-1:0]   rd1_q, rd1_d;
    logic [DW-1:0]   rd2_q, rd2_d;
    logic            rv1_q, rv2_q;
    logic            run;
    logic            wr_ok, rd1_ok, rd2_ok;
    logic            wr_en;

    assign run    = (state_q == RUN);
    assign wr_ok  = {1'b0, WriteAddress} < DEPTH_W;
    assign rd1_ok = {1'b0, ReadAddress1} < DEPTH_W;
    assign rd2_ok = {1'b0, ReadAddress2} < DEPTH_W;
    assign wr_en  = run & WE & wr_ok;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST) state_d = RUN;
            end
            RUN: begin
                state_d = RUN;
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Array itself has no reset; the sequencer owns it until RUN.
    always_ff @(posedge clock) begin
        if (!run) begin
            mem_q[ptr_q] <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < NB; k++) begin
                if (ByteEn[k]) mem_q[WriteAddress][8*k +: 8] <= WriteBus[8*k +: 8];
            end
        end
    end

    // Write-first: a same-edge write is merged into the read word.
    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic hit);
        logic [DW-1:0] w;
        w = old;
        for (int k = 0; k < NB; k++) begin
            if (hit && ByteEn[k]) w[8*k +: 8] = WriteBus[8*k +: 8];
        end
        return w;
    endfunction

    always_comb begin
        rd1_d = '0;
        rd2_d = '0;
        if (rd1_ok) rd1_d = merge(mem_q[ReadAddress1], wr_en && (WriteAddress == ReadAddress1));
        if (rd2_ok) rd2_d = merge(mem_q[ReadAddress2], wr_en && (WriteAddress == ReadAddress2));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd1_q <= '0;
            rd2_q <= '0;
            rv1_q <= 1'b0;
            rv2_q <= 1'b0;
        end else begin
            rv1_q <= run & RE1;
            rv2_q <= run & RE2;
            if (run && RE1) rd1_q <= rd1_d;
            if (run && RE2) rd2_q <= rd2_d;
        end
    end

    assign ReadBus1 = rd1_q;
    assign ReadBus2 = rd2_q;
    assign RValid1  = rv1_q;
    assign RValid2  = rv2_q;
    assign Ready    = run;

endmodule

// File: tb/tb_sram_dp_be.sv
// Directed bench for sram_dp_be: full-depth and DEPTH=1000 instances.
// Expected values are queued as stimulus is driven and checked after the edge.
module tb_sram_dp_be;

    logic        clock;
    logic        reset_n;
    logic        WE, RE1, RE2;
    logic [3:0]  ByteEn;
    logic [9:0]  WriteAddress, ReadAddress1, ReadAddress2;
    logic [31:0] WriteBus, ReadBus1, ReadBus2;
    logic        RValid1, RValid2, Ready;

    logic        s_WE, s_RE1, s_RE2;
    logic [3:0]  s_ByteEn;
    logic [9:0]  s_WriteAddress, s_ReadAddress1, s_ReadAddress2;
    logic [31:0] s_WriteBus, s_ReadBus1, s_ReadBus2;
    logic        s_RValid1, s_RValid2, s_Ready;

    int ntests = 0;
    int nfail  = 0;

    typedef struct {
        string       tag;
        int          d;
        int          p;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];

    sram_dp_be #(.DW(32), .AW(10), .DEPTH(1024)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .WE(WE), .ByteEn(ByteEn), .WriteAddress(WriteAddress), .WriteBus(WriteBus),
        .RE1(RE1), .ReadAddress1(ReadAddress1), .RE2(RE2), .ReadAddress2(ReadAddress2),
        .ReadBus1(ReadBus1), .ReadBus2(ReadBus2),
        .RValid1(RValid1), .RValid2(RValid2), .Ready(Ready)
    );

    sram_dp_be #(.DW(32), .AW(10), .DEPTH(1000)) u_sm (
        .clock(clock), .reset_n(reset_n),
        .WE(s_WE), .ByteEn(s_ByteEn), .WriteAddress(s_WriteAddress), .WriteBus(s_WriteBus),
        .RE1(s_RE1), .ReadAddress1(s_ReadAddress1), .RE2(s_RE2), .ReadAddress2(s_ReadAddress2),
        .ReadBus1(s_ReadBus1), .ReadBus2(s_ReadBus2),
        .RValid1(s_RValid1), .RValid2(s_RValid2), .Ready(s_Ready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] obs(int d, int p);
        if (d == 0) begin
            case (p)
                0: return ReadBus1;
                1: return ReadBus2;
                2: return 32'(RValid1);
                3: return 32'(RValid2);
                default: return 32'(Ready);
            endcase
        end
        case (p)
            0: return s_ReadBus1;
            1: return s_ReadBus2;
            2: return 32'(s_RValid1);
            3: return 32'(s_RValid2);
            default: return 32'(s_Ready);
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(string tag, int d, int p, logic [31:0] v);
        sb.push_back('{tag, d, p, v});
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, obs(e.d, e.p), e.v);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        WE = 0; RE1 = 0; RE2 = 0; ByteEn = 0;
        WriteAddress = 0; ReadAddress1 = 0; ReadAddress2 = 0; WriteBus = 0;
        s_WE = 0; s_RE1 = 0; s_RE2 = 0; s_ByteEn = 0;
        s_WriteAddress = 0; s_ReadAddress1 = 0; s_ReadAddress2 = 0; s_WriteBus = 0;
    endtask

    // Counts edges from reset release until each Ready rises.
    task automatic clear_run(input logic stress);
        int cb = 0;
        int cs = 0;
        int seen = 0;
        for (int c = 1; c <= 1100 && (cb == 0 || cs == 0); c++) begin
            if (stress && cb == 0) begin
                WE = 1; ByteEn = 4'hF; WriteAddress = 10'd3; WriteBus = 32'hFFFF_FFFF;
                RE1 = 1; RE2 = 1; ReadAddress1 = 10'd3; ReadAddress2 = 10'd7;
            end
            tick();
            if (cb == 0 && (RValid1 || RValid2 || ReadBus1 != 0 || ReadBus2 != 0)) seen = 1;
            if (Ready && cb == 0) cb = c;
            if (s_Ready && cs == 0) cs = c;
            if (cb != 0) idle();
        end
        check("ready_cycles", cb, 1024);
        check("sm_ready_cycles", cs, 1000);
        if (stress) check("clear_ignores_ports", seen, 0);
    endtask

    initial begin
        idle();
        reset_n = 0;
        #3;
        push("rst_rb1", 0, 0, 0); push("rst_rb2", 0, 1, 0);
        push("rst_rv1", 0, 2, 0); push("rst_rv2", 0, 3, 0);
        push("rst_ready", 0, 4, 0); push("sm_rst_ready", 1, 4, 0);
        drain();
        tick();
        #2 reset_n = 1;
        clear_run(1'b1);

        RE1 = 1; ReadAddress1 = 10'd0; RE2 = 1; ReadAddress2 = 10'd511;
        push("rd0", 0, 0, 0); push("rd0_v", 0, 2, 1);
        push("rd511", 0, 1, 0); push("rd511_v", 0, 3, 1);
        tick(); drain();
        ReadAddress1 = 10'd1023; ReadAddress2 = 10'd3;
        push("rd1023", 0, 0, 0); push("rd3_clear_wins", 0, 1, 0);
        tick(); drain();
        idle();

        WE = 1; ByteEn = 4'hF; WriteAddress = 10'd5; WriteBus = 32'hDEAD_BEEF;
        tick();
        idle(); RE1 = 1; ReadAddress1 = 10'd5;
        push("wr_full", 0, 0, 32'hDEAD_BEEF); push("wr_full_v", 0, 2, 1);
        tick(); drain();
        RE1 = 0;
        push("hold_rb1", 0, 0, 32'hDEAD_BEEF); push("hold_rv1", 0, 2, 0);
        tick(); drain();

        WE = 1; ByteEn = 4'b0101; WriteAddress = 10'd5; WriteBus = 32'h1122_3344;
        tick();
        idle(); RE2 = 1; ReadAddress2 = 10'd5;
        push("byte_en", 0, 1, 32'hDE22_BE44);
        tick(); drain();

        idle();
        WE = 1; ByteEn = 4'hF; WriteAddress = 10'd9; WriteBus = 32'hCAFE_F00D;
        RE1 = 1; RE2 = 1; ReadAddress1 = 10'd9; ReadAddress2 = 10'd9;
        push("bypass_p1", 0, 0, 32'hCAFE_F00D); push("bypass_p2", 0, 1, 32'hCAFE_F00D);
        tick(); drain();

        WE = 1; ByteEn = 4'b1000; WriteAddress = 10'd5; WriteBus = 32'hAA00_0000;
        RE1 = 1; ReadAddress1 = 10'd5; RE2 = 1; ReadAddress2 = 10'd9;
        push("bypass_part", 0, 0, 32'hAA22_BE44); push("no_bypass_p2", 0, 1, 32'hCAFE_F00D);
        tick(); drain();

        idle(); RE1 = 1; ReadAddress1 = 10'd5; RE2 = 1; ReadAddress2 = 10'd9;
        push("indep_p1", 0, 0, 32'hAA22_BE44); push("indep_p2", 0, 1, 32'hCAFE_F00D);
        tick(); drain();

        idle();
        s_WE = 1; s_ByteEn = 4'hF; s_WriteAddress = 10'd999; s_WriteBus = 32'h1234_5678;
        tick();
        s_WriteAddress = 10'd1000; s_WriteBus = 32'hFFFF_FFFF;
        s_RE1 = 1; s_ReadAddress1 = 10'd1000;
        push("oor_rdw", 1, 0, 0); push("oor_rdw_v", 1, 2, 1);
        tick(); drain();
        s_WE = 0; s_ReadAddress1 = 10'd1000; s_RE2 = 1; s_ReadAddress2 = 10'd999;
        push("oor_rd", 1, 0, 0); push("oor_rd_v", 1, 2, 1);
        push("sm_last", 1, 1, 32'h1234_5678); push("sm_last_v", 1, 3, 1);
        tick(); drain();
        idle();

        #2 reset_n = 0;
        #1;
        push("run_rst_rb1", 0, 0, 0); push("run_rst_rb2", 0, 1, 0);
        push("run_rst_ready", 0, 4, 0); push("sm_run_rst_rb2", 1, 1, 0);
        drain();
        tick();
        #2 reset_n = 1;
        for (int i = 0; i < 300; i++) tick();
        #2 reset_n = 0;
        #1;
        push("mid_clr_ready", 0, 4, 0);
        drain();
        tick();
        #2 reset_n = 1;
        clear_run(1'b0);

        RE1 = 1; ReadAddress1 = 10'd5; RE2 = 1; ReadAddress2 = 10'd9;
        push("recleared5", 0, 0, 0); push("recleared9", 0, 1, 0);
        s_RE1 = 1; s_ReadAddress1 = 10'd999;
        push("sm_recleared", 1, 0, 0);
        tick(); drain();
        idle();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
